// File: rtl/retry_start.sv
// Pass-through stage with an ID-indexed replay buffer. Retries replay a stored payload downstream.
// Optional replay statistics counter enabled by defining RETRY_START_STATS_EN.
module retry_start #(
    parameter type         DataType = logic,
    parameter int unsigned IDSize   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  DataType           data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output DataType           data_o,
    output logic [IDSize-1:0] id_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic [IDSize-1:0] retry_id_i,
    input  logic              retry_valid_i,
    output logic              retry_ready_o
`ifdef RETRY_START_STATS_EN
    ,
    output logic [15:0]       retry_count_o
`endif
);

    localparam int unsigned Depth = 1 << IDSize;

    typedef enum logic {
        PASS,
        REPLAY
    } mode_t;

    mode_t             mode_q;
    logic [IDSize-1:0] id_q;
    logic [IDSize-1:0] pend_id_q;
    DataType           mem [Depth];

    logic pend;
    logic pass_xfer;
    logic retry_take;
    logic replay_done;

    assign pend          = (mode_q == REPLAY);
    assign retry_ready_o = !pend || ready_i;
    assign pass_xfer     = !pend && valid_i && ready_i;
    assign retry_take    = retry_valid_i && retry_ready_o;
    assign replay_done   = pend && ready_i;

    always_comb begin
        data_o  = data_i;
        id_o    = id_q;
        valid_o = valid_i;
        ready_o = ready_i;
        if (pend) begin
            data_o  = mem[pend_id_q];
            id_o    = pend_id_q;
            valid_o = 1'b1;
            ready_o = 1'b0;
        end
    end

    // A retry captured alongside a PASS write to the same entry reads the new
    // data, since the replay is presented only from the following cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q    <= PASS;
            id_q      <= '0;
            pend_id_q <= '0;
            mem       <= '{default: '0};
        end else begin
            if (pass_xfer) begin
                mem[id_q] <= data_i;
                id_q      <= id_q + 1'b1;
            end
            if (retry_take) begin
                mode_q    <= REPLAY;
                pend_id_q <= retry_id_i;
            end else if (replay_done) begin
                mode_q <= PASS;
            end
        end
    end

`ifdef RETRY_START_STATS_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            retry_count_o <= '0;
        end else if (replay_done && (retry_count_o != 16'hFFFF)) begin
            retry_count_o <= retry_count_o + 16'd1;
        end
    end
`endif

endmodule
